pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter unit for the fetch stage.
- Selects sequential, PC-relative branch or absolute jump next-PC each cycle.
- Adds stall hold, boot bubble after reset, and misaligned-target trap redirect.
- Optional return-address stack predicts return targets.

Parameters:
- XLEN, 64, address width in bits.
- RESET_VEC, 40, PC value loaded on reset.
- STEP, 4, sequential increment in bytes; power of 2.
- IMM_SHIFT, 1, left shift applied to the branch immediate.
- TRAP_VEC, 256, PC loaded on a misaligned redirect.
- RAS_DEPTH, 4, return-address stack entries; power of 2, 2..16.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- stall  in  1  hold PC and all state this cycle.
- sel  in  2  00 sequential, 01 branch, 10 jump, 11 treated as 00.
- br_taken  in  1  branch condition; used only when sel=01.
- imm  in  XLEN  signed branch offset, before the shift.
- target  in  XLEN  absolute jump target.
- link  in  1  jump-and-link; push return address (RAS only).
- ret  in  1  return; jump to the RAS top (RAS only).
- pc  out  XLEN  current PC, registered.
- pc_next  out  XLEN  PC value to be loaded at the next edge (combinational).
- valid  out  1  pc is a real fetch address.
- trap  out  1  one-cycle misalignment trap indication.
- bad_addr  out  XLEN  last misaligned target, held until the next trap.
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.

Behaviour:
- Reset values (rst=0 at an edge): pc=RESET_VEC, valid=0, trap=0, bad_addr=0, ras_empty=1, ras_full=0, state=BOOT. Reset has priority over every other input.
- Arithmetic:
  - seq = pc + STEP.
  - br = pc + (imm << IMM_SHIFT); bits shifted out are discarded.
  - All sums are modulo 2^XLEN; carry is discarded and wrap-around is legal.
- Candidate next-PC, by sel:
  - 01 with br_taken=1: br.
  - 01 with br_taken=0: seq.
  - 10: target, or the RAS top when RAS is enabled, ret=1 and the RAS is not empty.
  - 00 or 11: seq.
- BOOT state: valid=0, pc holds RESET_VEC, inputs ignored; always goes to RUN at the next edge.
- RUN state: valid=1.
  - stall=1: pc, state, RAS and bad_addr hold; pc_next=pc.
  - stall=0, redirect (sel=01 taken, or sel=10) to a candidate not divisible by STEP: pc<=TRAP_VEC, bad_addr<=candidate, go to TRAP, RAS unchanged. pc_next shows TRAP_VEC.
  - stall=0, otherwise: pc<=candidate.
- TRAP state (one cycle): trap=1, valid=0, pc=TRAP_VEC, inputs and stall ignored; goes to RUN at the next edge.
- Latency: the redirect takes effect at the next edge. No added cycles except the BOOT and TRAP bubbles.

Optional Feature:
- Macro: PC_SEQUENCER_RAS_EN.
- With the macro:
  - Circular RAS of RAS_DEPTH entries.
  - Push happens on a RUN, non-stall, non-trapping cycle with sel=10 and link=1; the pushed value is seq.
  - ret=1 with sel=10 pops the top; when the RAS is empty, target is used and the pointer is unchanged.
  - link and ret together: pop then push, so depth is unchanged and the top is replaced.
  - Push when full overwrites the oldest entry; ras_full stays 1.
  - RAS state is cleared by reset only.
- Without the macro:
  - link and ret are ignored.
  - ras_empty ties to 1 and ras_full ties to 0.
  - No RAS storage is generated.

Test Plan:
- Reset then run, sel=00 → pc: 40 with valid=0, then 40 with valid=1, then 44, 48, 52.
- pc=100, sel=01, br_taken=1, imm=-8 → pc=84. Same with br_taken=0 → pc=104.
- pc=2^64-4, sel=00 → pc=0 (wrap-around); no trap.
- sel=10, target=0x1002 → next pc=256, trap=1 for exactly one cycle, valid=0, bad_addr=0x1002; the following cycle is RUN with pc=260 when sel=00.
- stall=1 for 3 cycles with sel=10 and target=0x2000 → pc holds. Release stall → pc=0x2000.
- RAS_EN build:
  - At pc=200, sel=10, link=1, target=0x400 → pc=0x400 and 204 is pushed.
  - Later, sel=10, ret=1, target=0 → pc=204 and ras_empty=1.
  - Five pushes with depth 4 → ras_full=1; the first-pushed value is lost.
- rst=0 asserted mid-TRAP → next pc=RESET_VEC, trap=0, state BOOT.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter with boot/trap bubbles and stall hold
// Optional return-address stack enabled by defining PC_SEQUENCER_RAS_EN.
module pc_sequencer #(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_VEC = 40,
  parameter int unsigned     STEP      = 4,
  parameter int unsigned     IMM_SHIFT = 1,
  parameter logic [XLEN-1:0] TRAP_VEC  = 256,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [1:0]      sel,
  input  logic            br_taken,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] target,
  input  logic            link,
  input  logic            ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            valid,
  output logic            trap,
  output logic [XLEN-1:0] bad_addr,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam logic [XLEN-1:0] STEP_W     = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_TRAP} state_t;

  state_t          state;
  logic [XLEN-1:0] seq;
  logic [XLEN-1:0] br;
  logic [XLEN-1:0] cand;
  logic [XLEN-1:0] ras_top;
  logic            ras_hit;
  logic            redirect;
  logic            misaligned;
  logic            active;

  assign seq = pc + STEP_W;
  assign br  = pc + (imm << IMM_SHIFT);

  always_comb begin
    cand = seq;
    case (sel)
      2'b01:   cand = br_taken ? br : seq;
      2'b10:   cand = ras_hit ? ras_top : target;
      default: cand = seq;
    endcase
  end

  assign redirect   = (sel == 2'b01 && br_taken) || (sel == 2'b10);
  assign misaligned = redirect && ((cand & ALIGN_MASK) != '0);
  assign active     = (state == ST_RUN) && !stall;

  // Leaving TRAP advances past the trap vector, which was presented as a bubble.
  always_comb begin
    pc_next = pc;
    case (state)
      ST_RUN:  if (!stall) pc_next = misaligned ? TRAP_VEC : cand;
      ST_TRAP: pc_next = seq;
      default: pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_BOOT;
      pc       <= RESET_VEC;
      valid    <= 1'b0;
      trap     <= 1'b0;
      bad_addr <= '0;
    end else begin
      pc <= pc_next;
      case (state)
        ST_BOOT: begin
          state <= ST_RUN;
          valid <= 1'b1;
        end
        ST_RUN: begin
          if (active && misaligned) begin
            state    <= ST_TRAP;
            valid    <= 1'b0;
            trap     <= 1'b1;
            bad_addr <= cand;
          end
        end
        ST_TRAP: begin
          state <= ST_RUN;
          valid <= 1'b1;
          trap  <= 1'b0;
        end
        default: begin
          state <= ST_BOOT;
          valid <= 1'b0;
          trap  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_SEQUENCER_RAS_EN
  localparam int unsigned   PW      = $clog2(RAS_DEPTH);
  localparam logic [PW:0]   DEPTH_W = (PW + 1)'(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_sp;
  logic [PW-1:0]   sp_inc;
  logic [PW:0]     ras_cnt;
  logic            ras_upd;

  assign sp_inc  = ras_sp + 1'b1;
  assign ras_top = ras_mem[ras_sp];
  assign ras_hit = ret && (ras_cnt != '0);
  assign ras_upd = active && !misaligned && (sel == 2'b10);

  // Circular stack: a push when full overwrites the oldest slot and keeps the count saturated.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ras_sp  <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_mem[i] <= '0;
    end else if (ras_upd) begin
      if (link && ras_hit) begin
        ras_mem[ras_sp] <= seq;
      end else if (link) begin
        ras_sp          <= sp_inc;
        ras_mem[sp_inc] <= seq;
        if (ras_cnt != DEPTH_W) ras_cnt <= ras_cnt + 1'b1;
      end else if (ras_hit) begin
        ras_sp  <= ras_sp - 1'b1;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == DEPTH_W);
`else
  logic unused_ras;

  assign unused_ras = ^{link, ret};
  assign ras_top    = '0;
  assign ras_hit    = 1'b0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
`endif

endmodule
